// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern-state sequencer.
//   seq_state_t       : sequencer FSM encoding (idle / granted / gap).
//   LED_W             : width of one pattern-state LED vector.
//   SLAVE_RST_PATTERN : LED vector a pattern-state block shows out of reset.
//   MAX_STATES        : most pattern-state blocks one sequencer can serve.
//   IDX_W             : width of a pattern-state index.
//   idx_onehot()      : index -> one-hot grant vector over MAX_STATES.
package led_seq_pkg;

   typedef enum logic [1:0] {
      SEQ_IDLE   = 2'd0,
      SEQ_ACTIVE = 2'd1,
      SEQ_GAP    = 2'd2
   } seq_state_t;

   localparam int LED_W      = 18;
   localparam int MAX_STATES = 8;
   localparam int IDX_W      = 3;

   localparam logic [LED_W-1:0] SLAVE_RST_PATTERN = 18'b000000000000000111;

   function automatic logic [MAX_STATES-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
      return MAX_STATES'(1) << idx;
   endfunction

endpackage

// File: rtl/led_dwell_counter.sv
// Dwell counter: counts enabled cycles since the last clear and flags when
// the count equals a (run-time selectable) terminal value.
//   clk     : system clock
//   sync_rs : synchronous active-high reset
//   clr     : synchronous clear (wins over en)
//   en      : count enable
//   term    : terminal count to compare against
//   at_term : high while the current count equals term
module led_dwell_counter #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             sync_rs,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] term,
   output logic             at_term
);

   logic [CNT_W-1:0] count_reg;

   // The owner clears the counter on every phase change, so the count never
   // runs past term and no wrap handling is needed.
   always_ff @(posedge clk) begin
      if (sync_rs || clr) begin
         count_reg <= '0;
      end else if (en) begin
         count_reg <= count_reg + CNT_W'(1);
      end
   end

   assign at_term = (count_reg == term);

endmodule

// File: rtl/led_state_sequencer.sv
// LED pattern sequencer: initiator side of the begin/over handshake.
// Grants one pattern state at a time, waits for its done flag (or a timeout),
// leaves a short all-low gap so the slave can drop its done flag, then grants
// the next state, wrapping to state 0. Muxes the granted state's LED vector
// onto the board LEDs.
//   clk         : system clock, rising edge
//   sync_rs     : synchronous active-high reset, highest priority
//   run         : global run level; low forces idle, resume starts at state 0
//   st_over     : done flag per pattern state (only the granted bit matters)
//   st_out_flat : LED vectors, state i at [i*LED_W +: LED_W]
//   st_begin    : one-hot grant to the pattern states
//   enabler     : shared enable level, high whenever the schedule runs
//   out         : board LED vector (granted slice, one cycle late)
//   active_idx  : index of the granted / last-granted state
//   timeout_err : sticky, some state overstayed TIMEOUT_CYC
module led_state_sequencer #(
   parameter int NUM_STATES  = 4,
   parameter int LED_W       = led_seq_pkg::LED_W,
   parameter int TIMEOUT_CYC = 64,
   parameter int GAP_CYC     = 1
) (
   input  logic                        clk,
   input  logic                        sync_rs,
   input  logic                        run,
   input  logic [NUM_STATES-1:0]       st_over,
   input  logic [NUM_STATES*LED_W-1:0] st_out_flat,
   output logic [NUM_STATES-1:0]       st_begin,
   output logic                        enabler,
   output logic [LED_W-1:0]            out,
   output logic [2:0]                  active_idx,
   output logic                        timeout_err
);

   import led_seq_pkg::*;

   // One counter times both the granted dwell and the gap, so size it for
   // the longer of the two.
   localparam int DWELL_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
   localparam int CNT_W     = $clog2(DWELL_MAX);

   localparam logic [CNT_W-1:0] TIMEOUT_TERM = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_TERM     = CNT_W'(GAP_CYC - 1);
   localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_STATES - 1);

   seq_state_t             state_reg, state_next;
   logic [IDX_W-1:0]       idx_reg, idx_next;
   logic [NUM_STATES-1:0]  begin_reg, begin_next;
   logic                   enabler_reg, enabler_next;
   logic [LED_W-1:0]       out_reg, out_next;
   logic                   timeout_reg, timeout_next;

   logic                   cnt_clr;
   logic                   cnt_en;
   logic [CNT_W-1:0]       cnt_term;
   logic                   cnt_at_term;
   logic [MAX_STATES-1:0]  grant_onehot;

   // Pad the per-state inputs out to MAX_STATES so a 3-bit index always
   // lands on a defined entry; unused entries read as zero.
   logic [LED_W-1:0]       slice_arr [MAX_STATES];
   logic [MAX_STATES-1:0]  over_pad;

   for (genvar gi = 0; gi < MAX_STATES; gi++) begin : g_pad
      if (gi < NUM_STATES) begin : g_used
         assign slice_arr[gi] = st_out_flat[gi*LED_W +: LED_W];
         assign over_pad[gi]  = st_over[gi];
      end else begin : g_unused
         assign slice_arr[gi] = '0;
         assign over_pad[gi]  = 1'b0;
      end
   end

   led_dwell_counter #(
      .CNT_W (CNT_W)
   ) u_dwell (
      .clk     (clk),
      .sync_rs (sync_rs),
      .clr     (cnt_clr),
      .en      (cnt_en),
      .term    (cnt_term),
      .at_term (cnt_at_term)
   );

   always_comb begin
      state_next   = state_reg;
      idx_next     = idx_reg;
      begin_next   = begin_reg;
      enabler_next = enabler_reg;
      out_next     = out_reg;
      timeout_next = timeout_reg;
      cnt_clr      = 1'b0;
      cnt_en       = 1'b0;
      grant_onehot = '0;
      cnt_term     = (state_reg == SEQ_GAP) ? GAP_TERM : TIMEOUT_TERM;

      case (state_reg)
         SEQ_IDLE: begin
            begin_next   = '0;
            enabler_next = 1'b0;
            out_next     = '0;
            idx_next     = '0;
            cnt_clr      = 1'b1;
            if (run) begin
               state_next   = SEQ_ACTIVE;
               grant_onehot = idx_onehot('0);
               begin_next   = grant_onehot[NUM_STATES-1:0];
               enabler_next = 1'b1;
            end
         end

         SEQ_ACTIVE: begin
            enabler_next = 1'b1;
            out_next     = slice_arr[idx_reg];
            cnt_en       = 1'b1;
            // Done flag is checked first so a done arriving on the final
            // allowed cycle counts as a normal completion.
            if (over_pad[idx_reg]) begin
               state_next = SEQ_GAP;
               begin_next = '0;
               cnt_clr    = 1'b1;
            end else if (cnt_at_term) begin
               timeout_next = 1'b1;
               state_next   = SEQ_GAP;
               begin_next   = '0;
               cnt_clr      = 1'b1;
            end
         end

         SEQ_GAP: begin
            cnt_en = 1'b1;
            if (cnt_at_term) begin
               idx_next     = (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
               grant_onehot = idx_onehot(idx_next);
               begin_next   = grant_onehot[NUM_STATES-1:0];
               state_next   = SEQ_ACTIVE;
               cnt_clr      = 1'b1;
            end
         end

         default: begin
            state_next = SEQ_IDLE;
         end
      endcase

      // Dropping run overrides everything decided above, including a done
      // flag or timeout in the same cycle; the error flag keeps its value.
      if (!run) begin
         state_next   = SEQ_IDLE;
         begin_next   = '0;
         enabler_next = 1'b0;
         out_next     = '0;
         idx_next     = '0;
         timeout_next = timeout_reg;
         cnt_clr      = 1'b1;
         cnt_en       = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (sync_rs) begin
         state_reg   <= SEQ_IDLE;
         idx_reg     <= '0;
         begin_reg   <= '0;
         enabler_reg <= 1'b0;
         out_reg     <= '0;
         timeout_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         idx_reg     <= idx_next;
         begin_reg   <= begin_next;
         enabler_reg <= enabler_next;
         out_reg     <= out_next;
         timeout_reg <= timeout_next;
      end
   end

   assign st_begin    = begin_reg;
   assign enabler     = enabler_reg;
   assign out         = out_reg;
   assign active_idx  = idx_reg;
   assign timeout_err = timeout_reg;

   // Two pattern states must never be granted in the same cycle.
   a_grant_onehot0 : assert property (@(posedge clk) disable iff (sync_rs) $onehot0(begin_reg));

endmodule

// File: tb/tb_led_state_sequencer.sv
// Self-checking bench for led_state_sequencer: behavioural slaves, a
// schedule-level reference model compared every cycle, directed scenarios
// with literal expectations, then a randomized soak.
module tb_led_state_sequencer;
   import led_seq_pkg::*;

   localparam int N    = 4;
   localparam int LW   = 18;
   localparam int TO   = 64;
   localparam int GAPC = 1;

   logic            clk = 1'b0;
   logic            sync_rs = 1'b1;
   logic            run = 1'b0;
   logic [N-1:0]    st_over = '0;
   logic [N*LW-1:0] st_out_flat = '0;
   logic [N-1:0]    st_begin;
   logic            enabler;
   logic [LW-1:0]   out;
   logic [2:0]      active_idx;
   logic            timeout_err;

   always #5 clk = ~clk;

   led_state_sequencer #(
      .NUM_STATES  (N),
      .LED_W       (LW),
      .TIMEOUT_CYC (TO),
      .GAP_CYC     (GAPC)
   ) dut (
      .clk         (clk),
      .sync_rs     (sync_rs),
      .run         (run),
      .st_over     (st_over),
      .st_out_flat (st_out_flat),
      .st_begin    (st_begin),
      .enabler     (enabler),
      .out         (out),
      .active_idx  (active_idx),
      .timeout_err (timeout_err)
   );

   int errors = 0;
   int checks = 0;

   // stimulus controls
   bit sr_drv = 1'b1, run_drv = 1'b0;
   bit noise_en = 1'b0, vec_rand = 1'b0, rand_dly = 1'b0;
   bit drop_arm = 1'b0, dropped = 1'b0;
   int dly [N];
   int seen [N];

   // reference model: which state holds the grant (-1 none), schedule position
   bit            m_valid = 1'b0;
   bit            m_on;
   int            m_grant, m_idx, m_dwell, m_gap_left;
   bit            m_err;
   logic [LW-1:0] m_out;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int pick_delay();
      case ($urandom % 6)
         0, 1, 2: return $urandom_range(0, 10);
         3:       return 62 + int'($urandom % 3);
         4:       return 1000;
         default: return $urandom_range(0, 30);
      endcase
   endfunction

   // Applies the inputs about to be sampled at the next rising edge.
   task automatic model_step();
      if (sync_rs) begin
         m_on = 0; m_grant = -1; m_idx = 0; m_dwell = 0; m_gap_left = 0;
         m_err = 0; m_out = '0;
      end else if (!run) begin
         m_on = 0; m_grant = -1; m_idx = 0; m_out = '0;
      end else if (!m_on) begin
         m_on = 1; m_grant = 0; m_idx = 0; m_dwell = 0;
      end else if (m_grant >= 0) begin
         m_out = st_out_flat[m_grant*LW +: LW];
         if (st_over[m_grant]) begin
            m_grant = -1; m_gap_left = GAPC;
         end else if (m_dwell == TO - 1) begin
            m_err = 1; m_grant = -1; m_gap_left = GAPC;
         end else begin
            m_dwell++;
         end
      end else begin
         m_gap_left--;
         if (m_gap_left == 0) begin
            m_idx = (m_idx + 1) % N;
            m_grant = m_idx;
            m_dwell = 0;
         end
      end
   endtask

   task automatic model_compare();
      logic [N-1:0] eb;
      eb = (m_grant >= 0) ? (N'(1) << m_grant) : '0;
      chk("st_begin", 32'(st_begin), 32'(eb));
      chk("enabler", 32'(enabler), 32'(m_on));
      chk("out", 32'(out), 32'(m_out));
      chk("active_idx", 32'(active_idx), 32'(m_idx));
      chk("timeout_err", 32'(timeout_err), 32'(m_err));
   endtask

   // One clock: compare at the falling edge, then drive the next inputs.
   task automatic tick();
      logic [N-1:0]    ov;
      logic [N*LW-1:0] vec;
      @(negedge clk);
      if (m_valid) model_compare();
      for (int i = 0; i < N; i++) begin
         if (st_begin[i] === 1'b1) begin
            if (seen[i] == 0 && rand_dly) dly[i] = pick_delay();
            seen[i]++;
            ov[i] = (seen[i] > dly[i]);
         end else begin
            seen[i] = 0;
            ov[i] = noise_en && ($urandom % 5 == 0);
         end
         if (vec_rand) vec[i*LW +: LW] = LW'($urandom);
         else          vec[i*LW +: LW] = SLAVE_RST_PATTERN << i;
      end
      if (drop_arm && st_begin[2] === 1'b1 && ov[2]) begin
         run_drv = 1'b0; drop_arm = 1'b0; dropped = 1'b1;
      end
      sync_rs = sr_drv;
      run = run_drv;
      st_over = ov;
      st_out_flat = vec;
      model_step();
      if (sync_rs) m_valid = 1'b1;
   endtask

   task automatic wait_begin(input logic [N-1:0] v, input string name);
      for (int k = 0; k < 300 && st_begin !== v; k++) tick();
      chk(name, 32'(st_begin), 32'(v));
   endtask

   task automatic count_grant(input logic [N-1:0] v, output int n);
      n = 0;
      while (st_begin === v && n < 200) begin
         n++;
         tick();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [N-1:0]  trb [20];
   logic [LW-1:0] tro [20];
   logic [2:0]    tri_ [20];
   int n;

   initial begin
      for (int i = 0; i < N; i++) begin dly[i] = 2; seen[i] = 0; end

      // reset
      repeat (3) tick();
      sr_drv = 1'b0;
      tick();
      chk("rst_begin", 32'(st_begin), 0);
      chk("rst_enabler", 32'(enabler), 0);
      chk("rst_out", 32'(out), 0);
      chk("rst_idx", 32'(active_idx), 0);
      chk("rst_err", 32'(timeout_err), 0);
      repeat (2) tick();
      chk("idle_begin", 32'(st_begin), 0);

      // first grant dwell + full rotation, noise on non-granted done flags
      noise_en = 1'b1;
      dly[0] = 5;
      run_drv = 1'b1;
      tick();
      for (int k = 0; k < 20; k++) begin
         tick();
         trb[k] = st_begin; tro[k] = out; tri_[k] = active_idx;
      end
      chk("rot_b0", 32'(trb[0]), 32'h1);
      chk("rot_b5", 32'(trb[5]), 32'h1);
      chk("rot_gap6", 32'(trb[6]), 32'h0);
      chk("rot_b7", 32'(trb[7]), 32'h2);
      chk("rot_idx7", 32'(tri_[7]), 1);
      chk("rot_b9", 32'(trb[9]), 32'h2);
      chk("rot_gap10", 32'(trb[10]), 32'h0);
      chk("rot_b11", 32'(trb[11]), 32'h4);
      chk("rot_b15", 32'(trb[15]), 32'h8);
      chk("rot_b19", 32'(trb[19]), 32'h1);
      chk("rot_out0", 32'(tro[0]), 32'h0);
      chk("rot_out1", 32'(tro[1]), 32'h7);
      chk("rot_out_gap", 32'(tro[6]), 32'h7);
      chk("rot_out8", 32'(tro[8]), 32'hE);
      chk("rot_err", 32'(timeout_err), 0);

      // slave 1 never finishes
      dly[0] = 2;
      dly[1] = 1000;
      wait_begin(4'b0010, "to_grant1");
      count_grant(4'b0010, n);
      chk("to_dwell", 32'(n), 64);
      chk("to_err", 32'(timeout_err), 1);
      tick();
      chk("to_next", 32'(st_begin), 32'h4);
      chk("to_idx", 32'(active_idx), 2);
      dly[1] = 2;
      wait_begin(4'b0001, "to_wrap");
      wait_begin(4'b0010, "to_g1b");
      wait_begin(4'b1000, "to_g3");
      chk("err_sticky", 32'(timeout_err), 1);

      // done exactly on the last allowed cycle
      sr_drv = 1'b1;
      tick();
      sr_drv = 1'b0;
      tick();
      chk("err_clr", 32'(timeout_err), 0);
      dly[0] = 63;
      wait_begin(4'b0001, "edge_grant0");
      count_grant(4'b0001, n);
      chk("edge_dwell", 32'(n), 64);
      chk("edge_err", 32'(timeout_err), 0);
      tick();
      chk("edge_next", 32'(st_begin), 32'h2);
      dly[0] = 2;

      // run dropped together with st_over[2]
      wait_begin(4'b0100, "drop_grant2");
      drop_arm = 1'b1;
      for (int k = 0; k < 20 && !dropped; k++) tick();
      chk("drop_fired", 32'(dropped), 1);
      tick();
      chk("drop_begin", 32'(st_begin), 0);
      chk("drop_enabler", 32'(enabler), 0);
      chk("drop_out", 32'(out), 0);
      chk("drop_idx", 32'(active_idx), 0);
      run_drv = 1'b1;
      tick();
      tick();
      chk("resume_begin", 32'(st_begin), 32'h1);

      // reset while state 2 holds the grant
      dly[2] = 10;
      wait_begin(4'b0100, "rs_grant2");
      sr_drv = 1'b1;
      tick();
      sr_drv = 1'b0;
      run_drv = 1'b0;
      tick();
      chk("rs_begin", 32'(st_begin), 0);
      chk("rs_enabler", 32'(enabler), 0);
      chk("rs_out", 32'(out), 0);
      chk("rs_idx", 32'(active_idx), 0);
      tick();
      chk("rs_idle", 32'(st_begin), 0);
      run_drv = 1'b1;
      tick();
      tick();
      chk("rs_regrant", 32'(st_begin), 32'h1);

      // randomized soak
      rand_dly = 1'b1;
      vec_rand = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         sr_drv = ($urandom % 600 == 0);
         if (run_drv && $urandom % 300 == 0) run_drv = 1'b0;
         else if (!run_drv && $urandom % 4 == 0) run_drv = 1'b1;
         tick();
      end
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/led_state_sequencer.md
Name: led_state_sequencer

Overview:
- Initiator side of the st*Begin / st*Over handshake used by the LED pattern-state blocks.
- Owns the pattern schedule: grants one pattern state at a time, waits for its done flag, then hands off to the next state, wrapping back to the first.
- Muxes the granted state's 18-bit LED vector onto the board LEDs.
- Drives the shared enabler level and flags any pattern state that never reports done.

Parameters:
- NUM_STATES, 4, number of pattern-state blocks served (2..8).
- LED_W, 18, LED vector width per state.
- TIMEOUT_CYC, 64, max clk cycles a state may stay granted before forced advance (>=2).
- GAP_CYC, 1, clk cycles with all grants low between states (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- sync_rs  in  1  reset, synchronous, active-high.
- run  in  1  global run switch (level).
- st_over  in  NUM_STATES  done flag per pattern state; bit i from state i.
- st_out_flat  in  NUM_STATES*LED_W  LED vectors; state i at bits [i*LED_W +: LED_W].
- st_begin  out  NUM_STATES  one-hot grant; bit i drives state i's begin input.
- enabler  out  1  shared enabler level to all pattern states.
- out  out  LED_W  board LED vector.
- active_idx  out  3  index of the granted/last-granted state.
- timeout_err  out  1  sticky: some state exceeded TIMEOUT_CYC.

Behaviour:
- Interface: one clock, clk; reset sync_rs, synchronous, active-high.
- sync_rs has priority over every other input. Reset values: state IDLE, st_begin=0, enabler=0, out=0, active_idx=0, timeout_err=0, cycle counter=0.
- All outputs are registered.
- FSM states: IDLE, ACTIVE, GAP.
- IDLE:
  - All grants low, enabler=0, out=0.
  - run=1 -> next cycle: ACTIVE, idx=0, st_begin=1<<0, enabler=1, counter=0.
- ACTIVE(idx):
  - st_begin = 1<<idx; enabler=1.
  - out <= slice idx of st_out_flat, giving 1-cycle latency from slave vector to out.
  - Counter increments every cycle.
  - st_over[idx]=1 -> GAP, counter=0.
  - Counter reaches TIMEOUT_CYC-1 with st_over[idx]=0 -> set timeout_err, go to GAP.
  - st_over[idx] and timeout in the same cycle -> normal completion; timeout_err is not set.
- st_over bits of non-granted states are ignored in all FSM states.
- GAP:
  - st_begin=0, so the slave clears its own done flag; enabler stays 1; out holds its last value.
  - After GAP_CYC cycles -> ACTIVE(idx+1). idx wraps from NUM_STATES-1 to 0.
  - active_idx updates on entry to ACTIVE.
- run=0 in any state -> next cycle IDLE, grants=0, enabler=0, out=0, active_idx=0.
  - run=0 beats a simultaneous st_over.
  - Resume always starts at state 0.
- run toggling mid-GAP behaves the same way: back to IDLE.
- timeout_err clears only on sync_rs.
- Invariant: st_begin is never multi-hot. There is never a cycle with two grants (checked by assertion).
- Widths: counter is $clog2(TIMEOUT_CYC) bits with no overflow; idx is 3 bits, compared against NUM_STATES-1 for wrap.

Decomposition:
- Package led_seq_pkg holds:
  - FSM state encoding (IDLE/ACTIVE/GAP).
  - LED_W=18.
  - Slave reset pattern constant 18'b000000000000000111, for bench checks.
  - Max NUM_STATES=8.
- One sub-module, led_dwell_counter: clear/enable counter with terminal-count compare. Used for both the timeout and the GAP length.

Test Plan:
- Reset then run=1, state0 raises st_over after 5 cycles -> st_begin=0001 for 5+1 cycles, then 0000 for 1 cycle, then 0010; active_idx=1.
- Full rotation with NUM_STATES=4, each slave finishing in 3 cycles -> st_begin sequence 0001,0010,0100,1000,0001; out equals granted slave vector one cycle delayed (e.g. 18'h00007 from state0); timeout_err=0.
- Slave1 never asserts st_over -> after 64 cycles timeout_err=1, advance to idx=2; timeout_err stays 1 through later normal rotations until sync_rs.
- st_over[idx] asserted exactly on counter=63 -> advance with timeout_err=0; st_over[3] pulsed while idx=0 -> ignored.
- run dropped the same cycle as st_over[2] -> next cycle IDLE, st_begin=0, enabler=0, out=0; run re-raised -> st_begin=0001.
- sync_rs asserted mid-ACTIVE(idx=2) -> next edge: all outputs at reset values; grant reissued at idx 0 only after run is sampled high.
